inst_buffer: RTL



---
 rtl/inst_buffer_pkg.sv | 21 ++
 rtl/inst_buffer_if.sv | 39 +++
 rtl/ParallelAdder.sv | 19 +
 rtl/inst_buffer.sv | 113 +++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the instruction buffer.
package inst_buffer_pkg;

    localparam int unsigned IBUF_BLOCK_INST_SIZE = 8;
    localparam int unsigned IBUF_DEPTH           = 32;
    localparam int unsigned DECODE_WIDTH         = 4;
    localparam int unsigned IBUF_FSQ_WIDTH       = 5;
    localparam int unsigned IBUF_PRED_WIDTH      = 4;

    // Pointer with one extra wrap bit above the entry index.
    typedef logic [$clog2(IBUF_DEPTH):0] IBufIdx;

    typedef struct packed {
        logic [31:0]                inst;
        logic [IBUF_FSQ_WIDTH-1:0]  fsqIdx;
        logic [IBUF_PRED_WIDTH-1:0] offset;
        logic                       ipf;
        logic                       iam;
    } IBufEntry;

endpackage

// File: rtl/inst_buffer_if.sv
// Predecode-to-ibuffer and ibuffer-to-decode signal bundle.
// master: predecode/decode environment; slave: the instruction buffer.
interface inst_buffer_if #(
    parameter int unsigned BLOCK_INST_SIZE  = inst_buffer_pkg::IBUF_BLOCK_INST_SIZE,
    parameter int unsigned DECODE_WIDTH     = inst_buffer_pkg::DECODE_WIDTH,
    parameter int unsigned FSQ_WIDTH        = inst_buffer_pkg::IBUF_FSQ_WIDTH,
    parameter int unsigned PREDICTION_WIDTH = inst_buffer_pkg::IBUF_PRED_WIDTH
);

    logic [BLOCK_INST_SIZE-1:0]                      pd_en;
    logic [$clog2(BLOCK_INST_SIZE):0]                pd_num;
    logic [BLOCK_INST_SIZE-1:0][31:0]                pd_inst;
    logic [FSQ_WIDTH-1:0]                            pd_fsq_idx;
    logic                                            pd_iam;
    logic [BLOCK_INST_SIZE-1:0]                      pd_ipf;
    logic [PREDICTION_WIDTH:0]                       pd_shift_idx;
    logic                                            redirect;
    logic                                            ibuf_full;
    logic                                            dec_ready;
    logic [DECODE_WIDTH-1:0]                         dec_valid;
    logic [DECODE_WIDTH-1:0][31:0]                   dec_inst;
    logic [DECODE_WIDTH-1:0][FSQ_WIDTH-1:0]          dec_fsq_idx;
    logic [DECODE_WIDTH-1:0][PREDICTION_WIDTH-1:0]   dec_offset;
    logic [DECODE_WIDTH-1:0]                         dec_ipf;
    logic [DECODE_WIDTH-1:0]                         dec_iam;

    modport master (
        output pd_en, pd_num, pd_inst, pd_fsq_idx, pd_iam, pd_ipf, pd_shift_idx,
        output redirect, dec_ready,
        input  ibuf_full, dec_valid, dec_inst, dec_fsq_idx, dec_offset, dec_ipf, dec_iam
    );

    modport slave (
        input  pd_en, pd_num, pd_inst, pd_fsq_idx, pd_iam, pd_ipf, pd_shift_idx,
        input  redirect, dec_ready,
        output ibuf_full, dec_valid, dec_inst, dec_fsq_idx, dec_offset, dec_ipf, dec_iam
    );

endinterface

// File: rtl/ParallelAdder.sv
// Population count of a bit vector.
module ParallelAdder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]        data,
    output logic [$clog2(WIDTH):0]  sum
);

    localparam int unsigned SW = $clog2(WIDTH) + 1;

    // Sum every input bit.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum = sum + SW'(data[i]);
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer between predecode and decode.
// Accepts a whole fetch block per cycle, presents the oldest DECODE_WIDTH
// entries, and is flushed by frontend redirects.
module inst_buffer #(
    parameter int unsigned BLOCK_INST_SIZE  = inst_buffer_pkg::IBUF_BLOCK_INST_SIZE,
    parameter int unsigned DEPTH            = inst_buffer_pkg::IBUF_DEPTH,
    parameter int unsigned DECODE_WIDTH     = inst_buffer_pkg::DECODE_WIDTH,
    parameter int unsigned FSQ_WIDTH        = inst_buffer_pkg::IBUF_FSQ_WIDTH,
    parameter int unsigned PREDICTION_WIDTH = inst_buffer_pkg::IBUF_PRED_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    inst_buffer_if.slave bus
);

    import inst_buffer_pkg::IBufEntry;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(BLOCK_INST_SIZE) + 1;

    typedef logic [AW:0] ptr_t;

    ptr_t           head;
    ptr_t           tail;
    ptr_t           count;
    ptr_t           wr_num;
    ptr_t           rd_num;
    ptr_t           rd_avail;
    logic           wr_en;
    logic [NW-1:0]  pd_en_cnt;

    IBufEntry       mem       [DEPTH];
    IBufEntry       wr_entry  [BLOCK_INST_SIZE];
    logic [AW-1:0]  wr_idx    [BLOCK_INST_SIZE];
    logic           wr_slot_en[BLOCK_INST_SIZE];
    IBufEntry       dec_entry [DECODE_WIDTH];

    // Full means a whole block might not fit; depends on registered count only.
    assign bus.ibuf_full = (ptr_t'(DEPTH) - count) < ptr_t'(BLOCK_INST_SIZE);

    // Enqueue/dequeue amounts for this edge; redirect suppresses both.
    always_comb begin
        wr_en    = (bus.pd_num != '0) && !bus.ibuf_full && !bus.redirect;
        wr_num   = wr_en ? ptr_t'(bus.pd_num) : '0;
        rd_avail = (count < ptr_t'(DECODE_WIDTH)) ? count : ptr_t'(DECODE_WIDTH);
        rd_num   = (bus.dec_ready && !bus.redirect) ? rd_avail : '0;
    end

    // Build the per-slot entries and their circular target indices.
    always_comb begin
        for (int unsigned i = 0; i < BLOCK_INST_SIZE; i++) begin
            wr_slot_en[i]      = wr_en && (NW'(i) < bus.pd_num);
            wr_idx[i]          = AW'(tail[AW-1:0] + AW'(i));
            wr_entry[i].inst   = bus.pd_inst[i];
            wr_entry[i].fsqIdx = bus.pd_fsq_idx;
            wr_entry[i].offset = PREDICTION_WIDTH'(bus.pd_shift_idx) + PREDICTION_WIDTH'(i);
            wr_entry[i].ipf    = bus.pd_ipf[i];
            wr_entry[i].iam    = (i == 0) ? bus.pd_iam : 1'b0;
        end
    end

    // Entry array write; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BLOCK_INST_SIZE; i++) begin
            if (wr_slot_en[i]) begin
                mem[wr_idx[i]] <= wr_entry[i];
            end
        end
    end

    // Pointer and occupancy update; redirect and reset both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + rd_num;
            tail  <= tail + wr_num;
            count <= count + wr_num - rd_num;
        end
    end

    // Present the oldest entries to decode.
    always_comb begin
        for (int unsigned j = 0; j < DECODE_WIDTH; j++) begin
            dec_entry[j]       = mem[AW'(head[AW-1:0] + AW'(j))];
            bus.dec_valid[j]   = ptr_t'(j) < count;
            bus.dec_inst[j]    = dec_entry[j].inst;
            bus.dec_fsq_idx[j] = dec_entry[j].fsqIdx;
            bus.dec_offset[j]  = dec_entry[j].offset;
            bus.dec_ipf[j]     = dec_entry[j].ipf;
            bus.dec_iam[j]     = dec_entry[j].iam;
        end
    end

    ParallelAdder #(
        .WIDTH(BLOCK_INST_SIZE)
    ) u_pd_popcnt (
        .data(bus.pd_en),
        .sum (pd_en_cnt)
    );

    // Interface sanity: pd_num matches pd_en, pd_en is contiguous, count bounded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (pd_en_cnt == bus.pd_num);
            assert ((bus.pd_en & (bus.pd_en + BLOCK_INST_SIZE'(1))) == '0);
            assert (count <= ptr_t'(DEPTH));
        end
    end

endmodule
